// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and a conditional two's-complement negate used for sign fixup.
package muldiv_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  // Widest value the negate helper handles; covers a full 2*WIDTH product for WIDTH <= 32.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // Returns -v (mod 2^MAXW) when en is set, else v. Callers truncate to their own width,
  // which keeps the result correct modulo 2^width.
  function automatic logic [MAXW-1:0] cneg(input logic [MAXW-1:0] v, input logic en);
    return en ? (~v + MAXW'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             start;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] Rdata1;
  logic [WIDTH-1:0] Rdata2;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, Rdata1, Rdata2, abort,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, Rdata1, Rdata2, abort,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared accumulator for shift-add multiply and restoring divide on unsigned magnitudes.
// acc_hi/acc_lo hold {product hi, product lo} or {remainder, quotient/dividend}.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the difference
    // and its top bit is a reliable borrow.
    div_diff  = div_shift - {1'b0, opnd};
    hi_nxt    = acc_hi;
    lo_nxt    = acc_lo;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= opa;
      opnd   <= opb;
    end else if (step) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
    end
  end

  assign res_hi = acc_hi;
  assign res_lo = acc_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO, busy/done handshake,
// sign fixup for signed ops and a sticky divide-by-zero flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic      CLK,
  input  logic      RST,
  muldiv_if.slave   bus
);

  // state | meaning
  // IDLE  | waiting for an issue; MTHI/MTLO complete here
  // CALC  | one radix-2 step per cycle (skipped straight to FIXUP on zero divisor)
  // FIXUP | apply result signs, write HI/LO, pulse done

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div_q, neg_lo_q, neg_hi_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div_zero_q;

  logic             op_md, op_div, op_signed, op_mthi, op_mtlo;
  logic             issue_ok, load, step, wr;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, dz_hi;

  always_comb begin
    op_md     = (bus.op == OPW'(OP_MULT)) || (bus.op == OPW'(OP_MULTU)) ||
                (bus.op == OPW'(OP_DIV))  || (bus.op == OPW'(OP_DIVU));
    op_div    = (bus.op == OPW'(OP_DIV))  || (bus.op == OPW'(OP_DIVU));
    op_signed = (bus.op == OPW'(OP_MULT)) || (bus.op == OPW'(OP_DIV));
    op_mthi   = (bus.op == OPW'(OP_MTHI));
    op_mtlo   = (bus.op == OPW'(OP_MTLO));
    issue_ok  = (state == IDLE) && bus.start && !bus.abort;
    s1        = op_signed && bus.Rdata1[WIDTH-1];
    s2        = op_signed && bus.Rdata2[WIDTH-1];
    mag1      = WIDTH'(cneg(MAXW'(bus.Rdata1), s1));
    mag2      = WIDTH'(cneg(MAXW'(bus.Rdata2), s2));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    wr        = 1'b0;
    case (state)
      IDLE: begin
        if (issue_ok && op_md) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (dz_q) begin
          state_nxt = FIXUP;
        end else begin
          step = 1'b1;
          if (cnt == CW'(1)) state_nxt = FIXUP;
        end
      end
      FIXUP: begin
        state_nxt = IDLE;
        if (!bus.abort) wr = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (load) begin
      cnt      <= CW'(WIDTH);
      is_div_q <= op_div;
      neg_lo_q <= s1 ^ s2;
      neg_hi_q <= s1;
      dz_q     <= op_div && (bus.Rdata2 == '0);
    end else if (step) begin
      cnt <= cnt - CW'(1);
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .step   (step),
    .is_div (op_div),
    .opa    (mag1),
    .opb    (mag2),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // On a zero divisor no step runs, so res_lo still holds |dividend|; re-signing it
  // with the remainder sign restores the original dividend for HI.
  always_comb begin
    prod_s = (2*WIDTH)'(cneg(MAXW'({res_hi, res_lo}), neg_lo_q));
    quo_s  = WIDTH'(cneg(MAXW'(res_lo), neg_lo_q));
    rem_s  = WIDTH'(cneg(MAXW'(res_hi), neg_hi_q));
    dz_hi  = WIDTH'(cneg(MAXW'(res_lo), neg_hi_q));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= wr;
      if (wr) begin
        if (!is_div_q) begin
          hi_q <= prod_s[2*WIDTH-1:WIDTH];
          lo_q <= prod_s[WIDTH-1:0];
        end else if (dz_q) begin
          hi_q       <= dz_hi;
          lo_q       <= '1;
          div_zero_q <= 1'b1;
        end else begin
          hi_q       <= rem_s;
          lo_q       <= quo_s;
          div_zero_q <= 1'b0;
        end
      end else if (issue_ok && op_mthi) begin
        hi_q <= bus.Rdata1;
      end else if (issue_ok && op_mtlo) begin
        lo_q <= bus.Rdata1;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  muldiv_if #(.WIDTH(W), .OPW(3)) bus ();
  muldiv_unit #(.WIDTH(W), .OPW(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic with MIPS conventions.
  task automatic model(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    longint unsigned pu;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      0: begin p = longint'(sa) * longint'(sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      1: begin pu = {32'd0, a} * {32'd0, b}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
      2: begin
        exp_dz = (b == 0);
        if (b == 0) begin exp_hi = a; exp_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin exp_lo = a; exp_hi = 0; end
        else begin exp_lo = sa / sb; exp_hi = sa % sb; end
      end
      3: begin
        exp_dz = (b == 0);
        if (b == 0) begin exp_hi = a; exp_lo = '1; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic issue(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 3'(o); bus.Rdata1 = a; bus.Rdata2 = b;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_md(input string tag, input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int lat;
    issue(o, a, b);
    model(o, a, b);
    lat = (o >= 2 && b == 0) ? 2 : W + 1;
    chk({tag, ".busy0"}, 64'(bus.busy), 64'd1);
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, ".cycles"}, 64'(n), 64'(lat));
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".HI"}, 64'(bus.HI), 64'(exp_hi));
    chk({tag, ".LO"}, 64'(bus.LO), 64'(exp_lo));
    chk({tag, ".dz"}, 64'(bus.div_zero), 64'(exp_dz));
    @(posedge CLK); #1;
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int o;
    logic [W-1:0] a, b;
    bus.start = 0; bus.op = 0; bus.Rdata1 = 0; bus.Rdata2 = 0; bus.abort = 0;
    #1;
    chk("rst.HI", 64'(bus.HI), 64'd0);
    chk("rst.LO", 64'(bus.LO), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.dz", 64'(bus.div_zero), 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;

    run_md("multu_max", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("mult_neg", 0, 32'hFFFF_FFFD, 32'd7);
    run_md("mult_min", 0, 32'h8000_0000, 32'h8000_0000);
    run_md("div_neg", 2, 32'hFFFF_FFF9, 32'd2);
    run_md("divu", 3, 32'hFFFF_FFF9, 32'd2);
    run_md("div_ovf", 2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divu_zero", 3, 32'd5, 32'd0);
    run_md("divu_clr", 3, 32'd6, 32'd3);
    run_md("div_zero_neg", 2, 32'hFFFF_FF00, 32'd0);
    run_md("mult_neg_neg", 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0);

    // MTHI then MTLO on consecutive edges
    issue(4, 32'h1234_5678, 0);
    exp_hi = 32'h1234_5678;
    chk("mthi.HI", 64'(bus.HI), 64'(exp_hi));
    chk("mthi.busy", 64'(bus.busy), 64'd0);
    issue(5, 32'h9ABC_DEF0, 0);
    exp_lo = 32'h9ABC_DEF0;
    chk("mtlo.LO", 64'(bus.LO), 64'(exp_lo));
    chk("mtlo.HI", 64'(bus.HI), 64'(exp_hi));
    chk("mtlo.busy", 64'(bus.busy), 64'd0);

    // abort and start together in IDLE: nothing accepted
    @(negedge CLK);
    bus.abort = 1; bus.start = 1; bus.op = 3'(4); bus.Rdata1 = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    bus.abort = 0; bus.start = 0;
    chk("abort_start.HI", 64'(bus.HI), 64'(exp_hi));
    chk("abort_start.busy", 64'(bus.busy), 64'd0);

    // MTHI while a MULT is in flight is ignored
    issue(0, 32'd6, 32'd7);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    bus.start = 1; bus.op = 3'(4); bus.Rdata1 = 32'hCAFE_F00D;
    @(negedge CLK);
    bus.start = 0;
    begin
      int n = 0;
      while (!bus.done && n < 100) begin @(posedge CLK); #1; n++; end
    end
    model(0, 32'd6, 32'd7);
    chk("busy_mthi.HI", 64'(bus.HI), 64'(exp_hi));
    chk("busy_mthi.LO", 64'(bus.LO), 64'(exp_lo));
    @(posedge CLK); #1;

    // abort at cycle 10 of a MULT
    issue(0, 32'h1111_1111, 32'h2222_2222);
    repeat (9) @(posedge CLK);
    @(negedge CLK); bus.abort = 1;
    @(posedge CLK); #1;
    bus.abort = 0;
    chk("abort.busy", 64'(bus.busy), 64'd0);
    chk("abort.done", 64'(bus.done), 64'd0);
    begin
      logic seen_done = 0;
      repeat (40) begin @(posedge CLK); #1; if (bus.done) seen_done = 1; end
      chk("abort.no_done", 64'(seen_done), 64'd0);
    end
    chk("abort.HI", 64'(bus.HI), 64'(exp_hi));
    chk("abort.LO", 64'(bus.LO), 64'(exp_lo));

    // random operations
    for (int i = 0; i < 16; i++) begin
      o = $urandom_range(0, 3);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_md($sformatf("rnd%0d", i), o, a, b);
    end

    // reset in the middle of a DIV
    issue(2, 32'd1000, 32'd7);
    repeat (5) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    #1;
    chk("midrst.HI", 64'(bus.HI), 64'd0);
    chk("midrst.LO", 64'(bus.LO), 64'd0);
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.dz", 64'(bus.div_zero), 64'd0);
    @(negedge CLK); RST = 1'b0;
    exp_hi = 0; exp_lo = 0; exp_dz = 0;
    run_md("post_rst", 3, 32'd100, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
